rs_cmd_gen: RTL and testbench

- Upstream driver for the set/reset flip-flop stage.
- Takes two raw, asynchronous, bouncy command inputs (set request, clear request) from buttons or an external link.
- Synchronizes and debounces each input, then detects its rising edge.
- Emits clean single-cycle s/r pulses; s and r are never high together, so the 2'b11 (q -> x) code is never presented downstream.

---
 rtl/rs_pkg.sv | 27 ++
 rtl/rs_cmd_gen_db_cell.sv | 62 ++++++
 rtl/rs_cmd_gen.sv | 80 ++++++++
 tb/tb_rs_cmd_gen.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared definitions for the set/reset command generator: default debounce
// sizing, arbitration priority encodings and the {r,s} command encoding.
package rs_pkg;

   // Default debounce length (clk cycles) and the counter width that holds it.
   localparam int DB_MAX_DEF = 1000000;
   localparam int CNT_W_DEF  = 20;

   // Simultaneous-edge priority selector values.
   localparam int PRIO_SET = 0;
   localparam int PRIO_RST = 1;

   // Command presented to the flip-flop stage, packed as {r, s}.
   // Code 2'b11 would drive the downstream latch to an undefined state and is
   // never produced.
   typedef enum logic [1:0] {
      HOLD = 2'b00,
      SET  = 2'b01,
      RST  = 2'b10
   } cmd_e;

   // True for every code that may legally be presented downstream.
   function automatic logic cmd_legal(input logic [1:0] code);
      return (code != 2'b11);
   endfunction

endpackage

// File: rtl/rs_cmd_gen_db_cell.sv
// One input channel: 2-flop synchronizer, restart-on-glitch debouncer and
// rising-edge detector on the accepted level.
module db_cell #(
   parameter int DB_MAX = 1000000,
   parameter int CNT_W  = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic lvl,
   output logic rise
);

   // Terminal count: the DB_MAX-th consecutive differing sample flips the level.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_MAX - 1);

   logic             sync1;
   logic             sync2;
   logic             lvl_q;
   logic             lvl_d;
   logic [CNT_W-1:0] cnt;

   // Bring the asynchronous input into the clk domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
      end
   end

   // Accept a new level only after it has differed from the current one for
   // DB_MAX consecutive cycles; any return to equality restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         lvl_q <= 1'b0;
      end else if (sync2 == lvl_q) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         lvl_q <= sync2;
         cnt   <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // One-cycle history of the accepted level for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl_d <= 1'b0;
      end else begin
         lvl_d <= lvl_q;
      end
   end

   assign lvl  = lvl_q;
   assign rise = lvl_q & ~lvl_d;

endmodule

// File: rtl/rs_cmd_gen.sv
// Command generator feeding the set/reset flip-flop stage: two independent
// debounced channels, same-cycle arbitration and registered s/r pulses that
// are never high together.
module rs_cmd_gen
   import rs_pkg::*;
#(
   parameter int DB_MAX = DB_MAX_DEF,
   parameter int CNT_W  = CNT_W_DEF,
   parameter int PRIO_R = PRIO_RST
) (
   input  logic clk,
   input  logic rst_n,
   input  logic set_raw,
   input  logic clr_raw,
   output logic s,
   output logic r,
   output logic conflict,
   output logic set_lvl,
   output logic clr_lvl
);

   logic rise_set;
   logic rise_clr;
   cmd_e cmd_nxt;
   cmd_e cmd_q;
   logic conf_nxt;
   logic conf_q;

   db_cell #(
      .DB_MAX (DB_MAX),
      .CNT_W  (CNT_W)
   ) u_db_set (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (set_raw),
      .lvl   (set_lvl),
      .rise  (rise_set)
   );

   db_cell #(
      .DB_MAX (DB_MAX),
      .CNT_W  (CNT_W)
   ) u_db_clr (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (clr_raw),
      .lvl   (clr_lvl),
      .rise  (rise_clr)
   );

   // Arbitrate the two rising edges; on a tie the losing press is dropped.
   always_comb begin
      cmd_nxt  = HOLD;
      conf_nxt = 1'b0;
      if (rise_set && rise_clr) begin
         conf_nxt = 1'b1;
         cmd_nxt  = (PRIO_R == PRIO_RST) ? RST : SET;
      end else if (rise_set) begin
         cmd_nxt = SET;
      end else if (rise_clr) begin
         cmd_nxt = RST;
      end
   end

   // Output registers: one-cycle pulses, cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q  <= HOLD;
         conf_q <= 1'b0;
      end else begin
         cmd_q  <= cmd_nxt;
         conf_q <= conf_nxt;
      end
   end

   assign s        = cmd_q[0];
   assign r        = cmd_q[1];
   assign conflict = conf_q;

endmodule

// File: tb/tb_rs_cmd_gen.sv
// Bench for rs_cmd_gen: two instances (r-priority and s-priority) share the
// same raw inputs; expected pulses are queued with their cycle number.
module tb_rs_cmd_gen;

   localparam int DB = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic set_raw = 1'b0;
   logic clr_raw = 1'b0;

   logic a_s, a_r, a_c, a_sl, a_cl;
   logic b_s, b_r, b_c, b_sl, b_cl;

   int cyc = 0;
   int total = 0;
   int bad = 0;
   int a_pulses = 0;
   int b_pulses = 0;

   // Queue entries: {cycle[15:0], conflict, r, s}
   logic [18:0] exp_a_q[$];
   logic [18:0] exp_b_q[$];

   // Reference model state (soak phase only)
   logic model_en = 1'b0;
   logic en_q = 1'b0;
   logic raw_s_q = 1'b0;
   logic raw_c_q = 1'b0;
   logic m_acc_s = 1'b0;
   logic m_acc_c = 1'b0;
   int   m_run_s = 0;
   int   m_run_c = 0;
   int   model_cnt = 0;

   rs_cmd_gen #(.DB_MAX(DB), .CNT_W(3), .PRIO_R(1)) dut_a (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_raw  (set_raw),
      .clr_raw  (clr_raw),
      .s        (a_s),
      .r        (a_r),
      .conflict (a_c),
      .set_lvl  (a_sl),
      .clr_lvl  (a_cl)
   );

   rs_cmd_gen #(.DB_MAX(DB), .CNT_W(3), .PRIO_R(0)) dut_b (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_raw  (set_raw),
      .clr_raw  (clr_raw),
      .s        (b_s),
      .r        (b_r),
      .conflict (b_c),
      .set_lvl  (b_sl),
      .clr_lvl  (b_cl)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      raw_s_q <= set_raw;
      raw_c_q <= clr_raw;
      en_q    <= model_en;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_pulse(input int at, input logic [2:0] ka, input logic [2:0] kb);
      exp_a_q.push_back({at[15:0], ka});
      exp_b_q.push_back({at[15:0], kb});
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_drained(input string tag);
      chk({tag, "_qa"}, exp_a_q.size(), 0);
      chk({tag, "_qb"}, exp_b_q.size(), 0);
   endtask

   // Reference model: a raw level is accepted after DB consecutive differing
   // samples; its pulse appears three cycles after the accepting sample.
   always @(negedge clk) begin
      logic rs_s;
      logic rs_c;
      rs_s = 1'b0;
      rs_c = 1'b0;
      if (en_q) begin
         if (raw_s_q != m_acc_s) begin
            m_run_s++;
            if (m_run_s == DB) begin
               m_acc_s = raw_s_q;
               m_run_s = 0;
               rs_s    = raw_s_q;
            end
         end else begin
            m_run_s = 0;
         end
         if (raw_c_q != m_acc_c) begin
            m_run_c++;
            if (m_run_c == DB) begin
               m_acc_c = raw_c_q;
               m_run_c = 0;
               rs_c    = raw_c_q;
            end
         end else begin
            m_run_c = 0;
         end
         if (rs_s || rs_c) begin
            model_cnt++;
            if (rs_s && rs_c)
               expect_pulse(cyc + 3, 3'b110, 3'b101);
            else if (rs_s)
               expect_pulse(cyc + 3, 3'b001, 3'b001);
            else
               expect_pulse(cyc + 3, 3'b010, 3'b010);
         end
      end
   end

   // Scoreboard monitor: exclusivity every cycle, every pulse matched in order.
   always @(negedge clk) begin
      logic [18:0] e;
      chk("a_excl", {31'b0, a_s & a_r}, 32'd0);
      chk("b_excl", {31'b0, b_s & b_r}, 32'd0);
      if (a_s || a_r || a_c) begin
         a_pulses++;
         if (exp_a_q.size() == 0) begin
            chk("a_unexpected", {13'b0, cyc[15:0], a_c, a_r, a_s}, 32'd0);
         end else begin
            e = exp_a_q.pop_front();
            chk("a_pulse", {13'b0, cyc[15:0], a_c, a_r, a_s}, {13'b0, e});
         end
      end
      if (b_s || b_r || b_c) begin
         b_pulses++;
         if (exp_b_q.size() == 0) begin
            chk("b_unexpected", {13'b0, cyc[15:0], b_c, b_r, b_s}, 32'd0);
         end else begin
            e = exp_b_q.pop_front();
            chk("b_pulse", {13'b0, cyc[15:0], b_c, b_r, b_s}, {13'b0, e});
         end
      end
   end

   // Watchdog
   initial begin
      #500000;
      bad++;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   // Directed sequence followed by a randomized soak
   initial begin
      int n;
      int base;
      int hs;
      int hc;

      // Reset phase
      rst_n = 1'b0;
      idle(5);
      chk("reset_outs", {22'b0, a_s, a_r, a_c, a_sl, a_cl, b_s, b_r, b_c, b_sl, b_cl}, 32'd0);
      rst_n = 1'b1;

      // Idle: everything stays low for 50 cycles
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         chk("idle_outs", {22'b0, a_s, a_r, a_c, a_sl, a_cl, b_s, b_r, b_c, b_sl, b_cl}, 32'd0);
      end

      // Clean set press held 20 cycles
      n = cyc;
      set_raw = 1'b1;
      expect_pulse(n + 7, 3'b001, 3'b001);
      idle(5);
      chk("set_lvl_early", {30'b0, a_sl, b_sl}, 32'd0);
      idle(1);
      chk("set_lvl_taken", {30'b0, a_sl, b_sl}, 32'd3);
      idle(14);
      set_raw = 1'b0;
      idle(15);
      chk("set_lvl_released", {30'b0, a_sl, b_sl}, 32'd0);
      chk_drained("clean_press");

      // Bouncy clear press
      clr_raw = 1'b1; idle(3);
      clr_raw = 1'b0; idle(1);
      clr_raw = 1'b1; idle(2);
      clr_raw = 1'b0; idle(1);
      n = cyc;
      clr_raw = 1'b1;
      expect_pulse(n + 7, 3'b010, 3'b010);
      idle(5);
      chk("clr_lvl_early", {30'b0, a_cl, b_cl}, 32'd0);
      idle(1);
      chk("clr_lvl_taken", {30'b0, a_cl, b_cl}, 32'd3);
      idle(14);
      clr_raw = 1'b0;
      idle(15);
      chk_drained("bounce");

      // Simultaneous rising edges
      n = cyc;
      set_raw = 1'b1;
      clr_raw = 1'b1;
      expect_pulse(n + 7, 3'b110, 3'b101);
      idle(12);
      chk("both_lvl", {28'b0, a_sl, a_cl, b_sl, b_cl}, 32'hf);
      set_raw = 1'b0;
      clr_raw = 1'b0;
      idle(15);
      chk_drained("simultaneous");

      // Reset during a partial count, input held through release
      n = cyc;
      set_raw = 1'b1;
      idle(4);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midreset_outs", {22'b0, a_s, a_r, a_c, a_sl, a_cl, b_s, b_r, b_c, b_sl, b_cl}, 32'd0);
      idle(2);
      n = cyc;
      rst_n = 1'b1;
      expect_pulse(n + 7, 3'b001, 3'b001);
      idle(12);
      set_raw = 1'b0;
      idle(15);
      chk_drained("midreset");

      // Randomized soak against the reference model
      base = a_pulses;
      model_cnt = 0;
      model_en = 1'b1;
      hs = 0;
      hc = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 31) == 0) begin
            set_raw = 1'b1;
            clr_raw = 1'b1;
            hs = 6;
            hc = 6;
         end else begin
            if (hs == 0) begin
               set_raw = 1'($urandom_range(0, 1));
               hs = $urandom_range(1, 8);
            end else begin
               hs--;
            end
            if (hc == 0) begin
               clr_raw = 1'($urandom_range(0, 1));
               hc = $urandom_range(1, 8);
            end else begin
               hc--;
            end
         end
         @(negedge clk);
      end
      set_raw = 1'b0;
      clr_raw = 1'b0;
      idle(20);
      model_en = 1'b0;
      idle(2);
      chk("soak_count_a", a_pulses - base, model_cnt);
      chk_drained("soak");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
